gf251_acc_32: RTL

- Lane-wise GF(251) accumulator. It sits directly downstream of the packed 4-lane GF(251) multiplier.
- It consumes the multiplier's 32-bit product word (four 8-bit lanes, o_o) and its done strobe as a valid.
- It sums a vector of products per lane mod 251, producing four parallel inner-product partial sums for the SDitH MPC arithmetic.
- A start/last framing delimits each vector.

---
 rtl/gf251_acc_32.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gf251_acc_32.sv
// Lane-wise GF(251) accumulator: sums a framed vector of packed 4x8-bit products per lane mod 251.
// Optional horizontal lane sum (o_hsum, extra HSUM state) when GF251_ACC_HSUM_EN is defined.
module gf251_acc_32 #(
    parameter int CNT_W = 16,
    parameter int LANES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic [8*LANES-1:0]   i_data,
    input  logic                 i_last,
    output logic [8*LANES-1:0]   o_acc,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_err
`ifdef GF251_ACC_HSUM_EN
    ,
    output logic [7:0]           o_hsum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
`ifdef GF251_ACC_HSUM_EN
        ,
        S_HSUM = 2'd3
`endif
    } state_t;

`ifdef GF251_ACC_HSUM_EN
    localparam state_t S_FINISH = S_HSUM;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t               state_q, state_d;
    logic [8*LANES-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;
    logic [8*LANES-1:0]   acc_sum;
    logic                 noncanon;

    function automatic logic [7:0] canon(input logic [7:0] b);
        return (b >= 8'd251) ? b - 8'd251 : b;
    endfunction

    function automatic logic [7:0] add_mod(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 9'd251) ? 8'(s - 9'd251) : s[7:0];
    endfunction

    // The first element of a vector (i_start together with i_valid) adds onto zero, not onto acc_q.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        acc_sum  = '0;
        noncanon = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            acc_sum[8*k +: 8] = add_mod(i_start ? 8'd0 : acc_q[8*k +: 8], canon(i_data[8*k +: 8]));
            noncanon          = noncanon | (i_data[8*k +: 8] >= 8'd251);
        end
    end

`ifdef GF251_ACC_HSUM_EN
    logic [7:0] hsum_q, hsum_d;

    // Four canonical lanes sum to at most 1000, so at most three subtractions of 251 are needed.
    function automatic logic [7:0] hsum_mod(input logic [8*LANES-1:0] a);
        logic [9:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) s = s + {2'b00, a[8*k +: 8]};
        if (s >= 10'd753)      return 8'(s - 10'd753);
        else if (s >= 10'd502) return 8'(s - 10'd502);
        else if (s >= 10'd251) return 8'(s - 10'd251);
        else                   return s[7:0];
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef GF251_ACC_HSUM_EN
        hsum_d  = hsum_q;
`endif
        if (i_start) begin
            acc_d   = i_valid ? acc_sum : '0;
            count_d = i_valid ? CNT_W'(1) : '0;
            err_d   = i_valid & noncanon;
            state_d = (i_valid && i_last) ? S_FINISH : S_ACC;
`ifdef GF251_ACC_HSUM_EN
            hsum_d  = '0;
`endif
        end else begin
            case (state_q)
                S_ACC: begin
                    if (i_valid) begin
                        acc_d   = acc_sum;
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        err_d   = err_q | noncanon;
                        if (i_last) state_d = S_FINISH;
                    end
                end
`ifdef GF251_ACC_HSUM_EN
                S_HSUM: begin
                    hsum_d  = hsum_mod(acc_q);
                    state_d = S_DONE;
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef GF251_ACC_HSUM_EN
            hsum_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef GF251_ACC_HSUM_EN
            hsum_q  <= hsum_d;
`endif
        end
    end

    assign o_acc   = acc_q;
    assign o_count = count_q;
    assign o_err   = err_q;
    assign o_done  = (state_q == S_DONE);
`ifdef GF251_ACC_HSUM_EN
    assign o_busy  = (state_q == S_ACC) || (state_q == S_HSUM);
    assign o_hsum  = hsum_q;
`else
    assign o_busy  = (state_q == S_ACC);
`endif

endmodule
